mem_arbiter: RTL and testbench

Shares one slow-memory port between the instruction cache and the data cache. Each cache's 128-bit line-fill/write-back request is granted in turn and forwarded to memory with stable registered address, data and opcode. The memory's ready and read data are routed back to the granted cache. The block sits between the two `cache` instances and the single external memory interface, replacing their separate memory ports.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-cache memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

  // Debug grant encodings
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // Default line address and line data widths
  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between I-cache and D-cache requests.
// Build option MEM_ARB_RR_EN: round-robin on ties using the last grant;
// otherwise fixed priority with D over I.
module mem_arb_pick (
  input  logic i_i_pend,
  input  logic i_d_pend,
`ifdef MEM_ARB_RR_EN
  input  logic i_last_d,
`endif
  output logic o_any,
  output logic o_pick_d
);

  assign o_any = i_i_pend | i_d_pend;

`ifdef MEM_ARB_RR_EN
  // On a tie, the side that did not win last time goes first.
  assign o_pick_d = i_d_pend & (~i_i_pend | ~i_last_d);
`else
  // D always wins; I only proceeds when D is quiet.
  assign o_pick_d = i_d_pend;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one slow memory port between the I-cache and the D-cache.
// A winner's op/addr/wdata are captured in IDLE and presented to memory
// from registers until mem_ready; ready is routed back to the winner only.
// Build option MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  arb_state_t        r_state;
  logic [1:0]        r_grant;
  logic              r_op_read;
  logic              r_op_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              w_i_pend;
  logic              w_d_pend;
  logic              w_any;
  logic              w_pick_d;
`ifdef MEM_ARB_RR_EN
  logic              r_last_d;
`endif

  assign w_i_pend = i_read | i_write;
  assign w_d_pend = d_read | d_write;

  mem_arb_pick u_pick (
    .i_i_pend (w_i_pend),
    .i_d_pend (w_d_pend),
`ifdef MEM_ARB_RR_EN
    .i_last_d (r_last_d),
`endif
    .o_any    (w_any),
    .o_pick_d (w_pick_d)
  );

  // Arbiter FSM: capture the winner's request in IDLE, hold it until mem_ready.
  // A simultaneous read+write is treated as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= GNT_NONE;
      r_op_read  <= 1'b0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_d   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            if (w_pick_d) begin
              r_state    <= SERVE_D;
              r_grant    <= GNT_D;
              r_op_write <= d_write;
              r_op_read  <= ~d_write;
              r_addr     <= d_addr;
              r_wdata    <= d_wdata;
            end else begin
              r_state    <= SERVE_I;
              r_grant    <= GNT_I;
              r_op_write <= i_write;
              r_op_read  <= ~i_write;
              r_addr     <= i_addr;
              r_wdata    <= i_wdata;
            end
`ifdef MEM_ARB_RR_EN
            r_last_d <= w_pick_d;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_ready) begin
            r_state    <= IDLE;
            r_grant    <= GNT_NONE;
            r_op_read  <= 1'b0;
            r_op_write <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_grant    <= GNT_NONE;
          r_op_read  <= 1'b0;
          r_op_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = r_op_read;
  assign mem_write = r_op_write;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign grant     = r_grant;

  // Completion is combinational from mem_ready, steered to the granted side only;
  // mem_ready in IDLE reaches neither cache.
  assign i_ready = (r_state == SERVE_I) & mem_ready;
  assign d_ready = (r_state == SERVE_D) & mem_ready;

  // Read data is broadcast; each cache qualifies it with its own ready.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    grant;

  int n_total = 0;
  int n_pass  = 0;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
    logic [1:0]    exp_gnt;
    logic          exp_mr;
    logic          exp_mw;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clear_req();
    i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    clear_req();
    if (v.is_d) begin
      d_read = v.rd; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_read = v.rd; i_write = v.wr; i_addr = v.addr; i_wdata = v.wdata;
    end
    tick();
    chk({t, " grant"},     128'(grant),     128'(v.exp_gnt));
    chk({t, " mem_read"},  128'(mem_read),  128'(v.exp_mr));
    chk({t, " mem_write"}, 128'(mem_write), 128'(v.exp_mw));
    chk({t, " mem_addr"},  128'(mem_addr),  128'(v.addr));
    chk({t, " mem_wdata"}, mem_wdata,       v.wdata);
    chk({t, " early_rdy"}, 128'({i_ready, d_ready}), 128'(2'b00));
    repeat (v.lat - 1) tick();
    chk({t, " hold_op"},   128'({mem_read, mem_write}), 128'({v.exp_mr, v.exp_mw}));
    mem_rdata = v.rdata;
    mem_ready = 1'b1;
    #1;
    chk({t, " ready"}, 128'({i_ready, d_ready}), v.is_d ? 128'(2'b01) : 128'(2'b10));
    chk({t, " rdata"}, v.is_d ? d_rdata : i_rdata, v.rdata);
    tick();
    mem_ready = 1'b0;
    clear_req();
    chk({t, " idle"}, 128'({grant, mem_read, mem_write}), 128'(4'b0000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_seq[4];

    vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h0000010, {4{32'h0}},        {16{8'hA5}},        8, 2'b01, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 28'h0000020, {4{32'h12345678}}, {4{32'h0}},         3, 2'b10, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 28'hFFFFFFF, {4{32'hDEADBEEF}}, {4{32'hCAFEF00D}},  1, 2'b10, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 28'h0ABCDEF, {4{32'h5A5A5A5A}}, {4{32'h01020304}},  2, 2'b10, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 28'h1234567, {4{32'hFFFF0000}}, {4{32'h99999999}},  4, 2'b01, 1'b0, 1'b1};

`ifdef MEM_ARB_RR_EN
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif

    // Reset state
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    clear_req();
    repeat (3) tick();
    chk("rst outputs", 128'({grant, mem_read, mem_write, i_ready, d_ready}), 128'(6'b0));
    chk("rst addr",    128'(mem_addr), 128'(0));
    chk("rst wdata",   mem_wdata, '0);
    rst_n = 1'b1;
    tick();

    // Simultaneous I read and D write: D first, then I one cycle after D's ready
    i_read = 1'b1; i_addr = 28'h0000010;
    d_write = 1'b1; d_addr = 28'h0000020; d_wdata = {4{32'h12345678}};
    tick();
    chk("tie first grant", 128'(grant), 128'(2'b10));
    chk("tie first op",    128'({mem_read, mem_write}), 128'(2'b01));
    chk("tie first addr",  128'(mem_addr), 128'(28'h20));
    repeat (2) tick();
    mem_ready = 1'b1; #1;
    chk("tie d_ready", 128'({i_ready, d_ready}), 128'(2'b01));
    tick();
    mem_ready = 1'b0; d_write = 1'b0;
    chk("tie gap idle", 128'({grant, mem_read}), 128'(3'b000));
    tick();
    chk("tie second grant", 128'(grant), 128'(2'b01));
    chk("tie second op",    128'({mem_read, mem_write}), 128'(2'b10));
    chk("tie second addr",  128'(mem_addr), 128'(28'h10));
    mem_ready = 1'b1; #1;
    chk("tie i_ready", 128'({i_ready, d_ready}), 128'(2'b10));
    tick();
    mem_ready = 1'b0; clear_req();

    // Table-driven single transactions
    for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

    // Continuous requests from both sides
    i_read = 1'b1; i_addr = 28'h0000100;
    d_write = 1'b1; d_addr = 28'h0000200; d_wdata = {4{32'h77777777}};
    tick();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("cont grant%0d", g), 128'(grant), 128'(exp_seq[g]));
      chk($sformatf("cont addr%0d", g), 128'(mem_addr),
          (exp_seq[g] == 2'b10) ? 128'(28'h200) : 128'(28'h100));
      mem_ready = 1'b1; #1;
      chk($sformatf("cont ready%0d", g), 128'({i_ready, d_ready}),
          (exp_seq[g] == 2'b10) ? 128'(2'b01) : 128'(2'b10));
      tick();
      mem_ready = 1'b0;
      chk($sformatf("cont gap%0d", g), 128'(grant), 128'(2'b00));
      tick();
    end
    clear_req();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();

    // Requester changes its inputs mid-service
    d_read = 1'b1; d_addr = 28'h0000030; d_wdata = {4{32'h11111111}};
    tick();
    chk("mid addr0", 128'(mem_addr), 128'(28'h30));
    d_addr = 28'h0000040; d_wdata = {4{32'h22222222}}; d_read = 1'b0; d_write = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid addr%0d", c + 1), 128'(mem_addr), 128'(28'h30));
      chk($sformatf("mid op%0d", c + 1), 128'({mem_read, mem_write}), 128'(2'b10));
    end
    chk("mid wdata", mem_wdata, {4{32'h11111111}});
    mem_ready = 1'b1; #1;
    chk("mid d_ready", 128'(d_ready), 128'(1));
    tick();
    mem_ready = 1'b0; clear_req();
    tick();

    // Reset asserted during SERVE_D
    d_write = 1'b1; d_addr = 28'h0000060; d_wdata = {4{32'h33333333}};
    tick();
    chk("pre-rst grant", 128'(grant), 128'(2'b10));
    tick();
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("mid-rst ctl",   128'({grant, mem_read, mem_write, i_ready, d_ready}), 128'(6'b0));
    chk("mid-rst addr",  128'(mem_addr), 128'(0));
    chk("mid-rst wdata", mem_wdata, '0);
    mem_ready = 1'b0; clear_req();
    i_read = 1'b1; i_addr = 28'h0000055;
    #2;
    rst_n = 1'b1;
    tick();
    chk("post-rst grant", 128'(grant), 128'(2'b01));
    chk("post-rst op",    128'({mem_read, mem_write}), 128'(2'b10));
    chk("post-rst addr",  128'(mem_addr), 128'(28'h55));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; clear_req();
    tick();

    // mem_ready while idle
    mem_ready = 1'b1; #1;
    chk("idle rdy", 128'({i_ready, d_ready}), 128'(2'b00));
    tick();
    mem_ready = 1'b0;
    chk("idle state", 128'({grant, mem_read, mem_write}), 128'(4'b0000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
